// File: rtl/sseg_share_if.sv
// Bundle between the display requesters and the sseg_share scheduler.
// The master side owns requests, words and the advance controls.
// The slave side (the scheduler) drives the word, owner and grant outputs.
interface sseg_share_if #(
  parameter int N = 4
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [32*N-1:0] words;
  logic            next;
  logic            hold;
  logic [31:0]     word_out;
  logic [OW-1:0]   owner;
  logic            owner_valid;
  logic [N-1:0]    grant;
  logic            slice_done;

  modport master (
    output req, words, next, hold,
    input  word_out, owner, owner_valid, grant, slice_done
  );

  modport slave (
    input  req, words, next, hold,
    output word_out, owner, owner_valid, grant, slice_done
  );
endinterface

// File: rtl/sseg_share.sv
// Round-robin time-slice scheduler for the shared 4-digit seven-segment display.
// Each owner keeps the display for SLICE cycles. When ownership passes to a
// different requester, the display goes blank for GAP cycles. Every output is
// registered, and each one is derived from the state being entered.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | nobody requesting, display shows spaces
//   BLANK | ownership changing, spaces shown for GAP cycles
//   SHOW  | owner's word on the display, slice timer running
module sseg_share #(
  parameter int N     = 4,
  parameter int SLICE = 200000000,
  parameter int GAP   = 2
) (
  input logic clk,
  input logic rst_n,
  sseg_share_if.slave bus
);
  localparam int          OW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [31:0] SPACES   = 32'h20202020;
  localparam logic [31:0] SLICE_M1 = 32'(SLICE - 1);
  localparam logic [31:0] GAP_M1   = (GAP > 0) ? 32'(GAP - 1) : 32'd0;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [31:0]   word_q, word_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic          pick_ok;
  logic [OW-1:0] pick_idx;
  logic          expire;
  logic          trig;

  // Round-robin search from owner+1, wrapping so that owner itself is tried last
  always_comb begin
    logic [OW-1:0] idx;
    idx      = '0;
    pick_ok  = 1'b0;
    pick_idx = owner_q;
    // Walk from the far end backwards so the nearest candidate is written last
    for (int k = N; k >= 1; k--) begin
      idx = OW'((int'(owner_q) + k) % N);
      if (bus.req[idx]) begin
        pick_ok  = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // Next-state, slice counter and owner selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    expire  = (cnt_q == SLICE_M1);
    trig    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = (GAP == 0) ? SHOW : BLANK;
        end
      end
      BLANK: begin
        if (cnt_q == GAP_M1) begin
          cnt_d = '0;
          // The requester may have gone away during the blank, so look again
          if (bus.req[owner_q]) begin
            state_d = SHOW;
          end else if (pick_ok) begin
            owner_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      SHOW: begin
        // A click overrides hold; several triggers together still give one step
        trig = !bus.req[owner_q] || bus.next || (expire && !bus.hold);
        if (trig) begin
          cnt_d = '0;
          if (!pick_ok) begin
            state_d = IDLE;
          end else if (pick_idx != owner_q) begin
            owner_d = pick_idx;
            state_d = (GAP == 0) ? SHOW : BLANK;
          end
        end else begin
          // With hold set, an expired slice wraps and the owner keeps the display
          cnt_d = expire ? 32'd0 : cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode follows the state being entered, so the outputs line up with it
  always_comb begin
    word_d  = SPACES;
    grant_d = '0;
    valid_d = (state_d == SHOW);
    done_d  = (state_q == SHOW) && expire;
    for (int i = 0; i < N; i++) begin
      if (owner_d == OW'(i)) begin
        grant_d[i] = valid_d;
        if (valid_d) word_d = bus.words[32*i +: 32];
      end
    end
  end

  // State, counter and owner registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OW'(N - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  // Registered outputs toward the display driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= SPACES;
      grant_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.word_out    = word_q;
  assign bus.owner       = owner_q;
  assign bus.owner_valid = valid_q;
  assign bus.grant       = grant_q;
  assign bus.slice_done  = done_q;
endmodule

// File: tb/tb_sseg_share.sv
// Directed bench for sseg_share with N=4, SLICE=8, GAP=2.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_sseg_share;
  localparam logic [31:0] SPACES = 32'h20202020;
  localparam logic [31:0] W0 = "ab01";
  localparam logic [31:0] W1 = "ef11";
  localparam logic [31:0] W2 = "cd02";
  localparam logic [31:0] W3 = "gh33";

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   pulses;
  int   moved;

  sseg_share_if #(.N(4)) bus ();

  sseg_share #(.N(4), .SLICE(8), .GAP(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect the display to be showing requester o
  task automatic chk_show(input string tag, input int o, input logic [31:0] w);
    chk({tag, "_valid"}, 32'(bus.owner_valid), 32'd1);
    chk({tag, "_owner"}, 32'(bus.owner), 32'(o));
    chk({tag, "_grant"}, 32'(bus.grant), 32'd1 << o);
    chk({tag, "_word"}, bus.word_out, w);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.req   = '0;
    bus.next  = 1'b0;
    bus.hold  = 1'b0;
    bus.words = {W3, W2, W1, W0};

    // 1: reset values, then first grant after two blank cycles
    step(2);
    chk("rst_word", bus.word_out, SPACES);
    chk("rst_done", 32'(bus.slice_done), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("idle_word", bus.word_out, SPACES);
    chk("idle_grant", 32'(bus.grant), 32'd0);
    chk("idle_valid", 32'(bus.owner_valid), 32'd0);
    chk("idle_owner", 32'(bus.owner), 32'd3);
    bus.req = 4'b0101;
    step(1);
    chk("blank1_valid", 32'(bus.owner_valid), 32'd0);
    chk("blank1_owner", 32'(bus.owner), 32'd0);
    chk("blank1_word", bus.word_out, SPACES);
    step(1);
    chk("blank2_valid", 32'(bus.owner_valid), 32'd0);
    step(1);
    chk_show("first", 0, W0);

    // 2: alternate 0 -> 2 -> 0 with blanks, slice_done once per slice
    step(7);
    chk_show("s0_end", 0, W0);
    chk("s0_end_done", 32'(bus.slice_done), 32'd0);
    step(1);
    chk("s0_exp_done", 32'(bus.slice_done), 32'd1);
    chk("s0_exp_valid", 32'(bus.owner_valid), 32'd0);
    chk("s0_exp_owner", 32'(bus.owner), 32'd2);
    step(1);
    chk("gap_done", 32'(bus.slice_done), 32'd0);
    chk("gap_valid", 32'(bus.owner_valid), 32'd0);
    step(1);
    chk_show("s2", 2, W2);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      pulses += int'(bus.slice_done);
    end
    chk("s2_pulses", 32'(pulses), 32'd1);
    chk_show("back0", 0, W0);

    // 3: lone requester keeps the display, no blanks, expiry every 8 cycles
    bus.req = 4'b0010;
    step(3);
    chk_show("lone", 1, W1);
    pulses = 0;
    moved  = 0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      pulses += int'(bus.slice_done);
      if (!bus.owner_valid || bus.owner != 2'd1) moved++;
    end
    chk("lone_pulses", 32'(pulses), 32'd3);
    chk("lone_blanks", 32'(moved), 32'd0);

    // 4: click at cnt=3 advances 1 -> 2; click held into BLANK is ignored
    bus.req = 4'b1111;
    step(3);
    bus.next = 1'b1;
    step(1);
    chk("click_valid", 32'(bus.owner_valid), 32'd0);
    chk("click_owner", 32'(bus.owner), 32'd2);
    step(1);
    bus.next = 1'b0;
    chk("blank_click_owner", 32'(bus.owner), 32'd2);
    chk("blank_click_valid", 32'(bus.owner_valid), 32'd0);
    step(1);
    chk_show("after_click", 2, W2);

    // 5: hold keeps owner 0 across three expiries; click still advances
    bus.req  = 4'b0011;
    bus.hold = 1'b1;
    step(3);
    chk_show("hold", 0, W0);
    pulses = 0;
    moved  = 0;
    for (int i = 0; i < 26; i++) begin
      step(1);
      pulses += int'(bus.slice_done);
      if (!bus.owner_valid || bus.owner != 2'd0) moved++;
    end
    chk("hold_pulses", 32'(pulses), 32'd3);
    chk("hold_moved", 32'(moved), 32'd0);
    bus.next = 1'b1;
    step(1);
    bus.next = 1'b0;
    chk("hold_click_owner", 32'(bus.owner), 32'd1);
    chk("hold_click_valid", 32'(bus.owner_valid), 32'd0);
    step(2);
    chk_show("hold_next", 1, W1);

    // 6: last requester drops -> IDLE; async reset mid-SHOW
    bus.hold = 1'b0;
    bus.req  = 4'b0000;
    step(1);
    chk("drop_word", bus.word_out, SPACES);
    chk("drop_valid", 32'(bus.owner_valid), 32'd0);
    chk("drop_grant", 32'(bus.grant), 32'd0);
    bus.req = 4'b0001;
    step(3);
    chk_show("rearm", 0, W0);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("arst_word", bus.word_out, SPACES);
    chk("arst_grant", 32'(bus.grant), 32'd0);
    chk("arst_valid", 32'(bus.owner_valid), 32'd0);
    chk("arst_owner", 32'(bus.owner), 32'd3);
    chk("arst_done", 32'(bus.slice_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sseg_share.md
Name: sseg_share

Overview:
- Time-slice scheduler that shares the single 4-digit seven-segment display among N requesters.
- Each requester presents a 32-bit ASCII word (4 chars, MSB char leftmost) and a request bit.
- The block grants the display round-robin, one slice each, and drives the selected word into the seven-segment word driver.
- Sits between CPU/debug producers and the display driver; an optional pushbutton-click pulse forces an early advance.

Parameters:
- N, 4, number of requesters (2..8).
- SLICE, 200000000, cycles per ownership slice (2 s at 100 MHz); must be >= 2.
- GAP, 2, blank cycles inserted when ownership changes to a different requester; 0 disables.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request bits; req[i]=1 means requester i wants the display.
- words  in  32*N  word i at bits [32*i+31:32*i].
- next  in  1  single-cycle advance pulse (click output).
- hold  in  1  level; 1 suppresses timer-driven advance.
- word_out  out  32  word for the display driver.
- owner  out  clog2(N)  index of current/pending owner.
- owner_valid  out  1  1 only in SHOW.
- grant  out  N  one-hot grant in SHOW, else 0.
- slice_done  out  1  one-cycle pulse on slice timer expiry.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n), effective immediately, including mid-slice or mid-gap.
- Reset values:
  - state=IDLE, cnt=0, owner=N-1 (so the first search starts at 0).
  - word_out=32'h20202020 (four spaces), owner_valid=0, grant=0, slice_done=0.
- All outputs are registered.
- Arbitration function pick(p):
  - Returns the first index with req set in the order p+1, p+2, ... mod N, ending with p itself.
  - Returns none if req==0.
- IDLE:
  - word_out = spaces.
  - If req!=0: owner<=pick(owner) and cnt<=0.
  - Next state is SHOW if GAP==0, else BLANK.
- BLANK:
  - word_out = spaces, grant=0, owner_valid=0; cnt counts 0..GAP-1.
  - At cnt==GAP-1, re-check req[owner]:
    - If set: go to SHOW with cnt<=0.
    - Else if pick(owner) exists: owner<=pick(owner), restart BLANK.
    - Else: go to IDLE.
- SHOW:
  - word_out<=words[owner] every cycle (1-cycle latency from words to word_out).
  - grant=1<<owner, owner_valid=1, cnt increments.
- Advance triggers in SHOW (evaluated each cycle):
  - (a) req[owner]==0;
  - (b) next==1;
  - (c) cnt==SLICE-1 and hold==0.
- Advance result:
  - n=pick(owner).
  - If none: go to IDLE, word_out<=spaces.
  - If n==owner: stay in SHOW, cnt<=0, no blank.
  - Else: owner<=n, cnt<=0, go to BLANK (or SHOW directly if GAP==0).
  - The new grant is visible the cycle after the trigger.
- slice_done pulses for one cycle whenever cnt==SLICE-1 in SHOW, even if hold is set.
- If hold is set at expiry, cnt wraps to 0 and the owner is kept.
- Simultaneous events:
  - Multiple triggers in one cycle cause a single advance.
  - next overrides hold.
  - Drop (a) plus next (b) still advances exactly one position from the current owner.
- next in IDLE or BLANK is ignored.
- Requests that appear or disappear mid-slice do not disturb the current owner, except via trigger (a).
- cnt is 32 bits and never exceeds max(SLICE,GAP)-1.

Test Plan:
Bench uses N=4, SLICE=8, GAP=2.
1. Reset with req=0 -> word_out=32'h20202020, grant=0, owner_valid=0; set req=4'b0101 with word0="ab01", word2="cd02" -> 2 blank cycles, then SHOW with owner=0, grant=0001, word_out="ab01".
2. Hold req=0101 -> owner alternates 0,2,0 every 8 SHOW cycles plus 2 blank cycles; slice_done pulses once per slice.
3. Single requester req=0010 held for 24 cycles -> owner stays 1, no blank cycles, slice_done pulses every 8 cycles.
4. req=1111, owner=1, pulse next at cnt=3 -> blank starts next cycle, then owner=2; next during BLANK -> ignored.
5. hold=1 with req=0011, owner=0 -> owner stays 0 past 3 expiries with slice_done pulsing; next pulse -> owner=1.
6. Owner drops req mid-slice with no other requesters -> IDLE with spaces the next cycle; rst_n low mid-SHOW -> outputs return to reset values immediately.
